ps2_keyboard_fifo: RTL and testbench
====================================

Name: ps2_keyboard_fifo

Overview:
- Next-generation PS/2 keyboard receiver.
- Deserialises 11-bit PS/2 frames and checks start, odd parity and stop bits.
- Decodes the E0 (extended) and F0 (break) prefixes into per-key events and buffers them in a parametrised FIFO behind a valid/ready interface.
- Sits between the board PS/2 pins and the CPU-side keyboard device register, replacing the single-byte, pulse-only receiver.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, minimum 2.
- SYNC_STAGES, 3, flops in the ps2_clk synchroniser chain; minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the level output.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- out_valid  out  1  FIFO non-empty; head event on out_code/out_ext/out_brk
- out_ready  in  1  consumer accepts head event when out_valid=1
- out_code  out  8  head event scan code
- out_ext  out  1  head event was preceded by E0
- out_brk  out  1  head event was preceded by F0 (key release)
- level  out  CNT_W  number of events stored
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- parity_err  out  1  one-cycle pulse: frame rejected for start, parity or stop error
- frame_err  out  1  one-cycle pulse: partial frame discarded by timeout
- clear  in  1  synchronous: clears overflow, empties the FIFO, returns the decoder to IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, FIFO empty, decoder IDLE.
  - Bit counter 0, timeout counter 0, synchroniser flops 1 (idle bus).
  - Reset mid-frame discards the partial frame and any pending prefix.
- Sampling:
  - ps2_clk passes through SYNC_STAGES flops.
  - A falling edge is detected as last stage 1 and second-to-last stage 0; the bit is sampled on that edge.
  - ps2_data is sampled in the same cycle, through a 2-flop synchroniser.
- Frame format: bit 0 start (must be 0), bits 1-8 data LSB first, bit 9 odd parity over bits 1-9, bit 10 stop (must be 1).
- Frame completion (at the 11th falling edge):
  - The bit counter always returns to 0.
  - Good frame: a byte_ok strobe is asserted in the next cycle.
  - Bad frame: parity_err pulses in the next cycle, the byte is discarded and decoder state is unchanged.
- Timeout:
  - While the bit counter is nonzero, the timeout counter increments each clk and resets on every falling edge.
  - On reaching TIMEOUT_CYCLES: bit counter set to 0, frame_err pulses for one cycle, decoder state unchanged.
- Decoder FSM, advancing on byte_ok only. States IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte pushes {ext=0, brk=0, code} and stays in IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; other pushes {1, 0, code} and goes to IDLE.
  - BRK: E0 goes to EXT_BRK; F0 stays in BRK; other pushes {0, 1, code} and goes to IDLE.
  - EXT_BRK: E0 or F0 stays in EXT_BRK; other pushes {1, 1, code} and goes to IDLE.
  - E1 and every other byte are ordinary codes.
- Push timing: the push occurs in the cycle after byte_ok. out_valid is high in the cycle after the push, 3 clk after the cycle detecting the 11th falling edge.
- FIFO:
  - First-word fall-through. The head is presented while out_valid=1.
  - A pop occurs when out_valid and out_ready are both 1.
  - Head fields are stable while out_valid=1 and out_ready=0.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; level tracks occupancy exactly.
- FIFO boundaries:
  - Push while full with no pop: the event is dropped, overflow is set, stored contents are unchanged.
  - Push and pop in the same cycle while full: both proceed, level is unchanged, overflow is not set.
  - Push and pop in the same cycle while empty: the push proceeds; nothing is popped because out_valid=0.
  - out_ready while empty is ignored.
- clear: takes effect on the next edge and has priority over a same-cycle push or pop.

Test Plan:
- Frame 0x1C with correct parity -> 3 clk after the 11th falling edge, out_valid=1, out_code=0x1C, ext=0, brk=0, level=1; out_ready=1 for one cycle -> out_valid=0, level=0.
- Sequence F0,1C then E0,F0,75 with out_ready=0 -> two entries in order: {0x1C, ext=0, brk=1} then {0x75, ext=1, brk=1}; level=2, decoder IDLE.
- Frame 0x1C with parity bit inverted -> parity_err pulses once, no push, level unchanged; a following good 0x1C pushes {0x1C, 0, 0}.
- 9 distinct make codes 0x01..0x09 with out_ready=0, FIFO_DEPTH=8 -> level=8, overflow=1 from the 9th event onward, pops return 0x01..0x08; clear -> overflow=0.
- Five bits of a frame, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulses once, bit counter 0; the next full 0x2A frame decodes to {0x2A, 0, 0}.
- reset driven low mid-frame after E0 is received -> all outputs 0 immediately; after release, frame 0x75 pushes {0x75, ext=0, brk=0}.

Source files
------------

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: synchronises the bus, checks 11-bit frames, folds E0/F0
// prefixes into key events and queues them in a first-word-fall-through FIFO.
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic             out_ext,
  output logic             out_brk,
  output logic [CNT_W-1:0] level,
  output logic             overflow,
  output logic             parity_err,
  output logic             frame_err,
  input  logic             clear
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  logic [SYNC_STAGES-1:0] ck_sync_q;
  logic [1:0]             dt_sync_q;
  logic                   fall;
  logic                   bit_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
    end else begin
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dt_sync_q <= {dt_sync_q[0], ps2_data};
    end
  end

  assign fall   = ck_sync_q[SYNC_STAGES-1] & ~ck_sync_q[SYNC_STAGES-2];
  assign bit_in = dt_sync_q[1];

  // Bits shift in from the top: after ten edges shift_q holds {parity, data, start}
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;
  logic [TW-1:0] tmo_q;
  logic          byte_ok_q;
  logic [7:0]    byte_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          frame_good;

  assign frame_good = ~shift_q[0] & (^shift_q[9:1]) & bit_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      byte_ok_q    <= 1'b0;
      byte_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_ok_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          byte_q    <= shift_q[8:1];
          if (frame_good) byte_ok_q    <= 1'b1;
          else            parity_err_q <= 1'b1;
        end else begin
          shift_q   <= {bit_in, shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (tmo_q == TMO_LAST) begin
          bit_cnt_q   <= '0;
          tmo_q       <= '0;
          frame_err_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  state_t     state_q;
  logic       push_q;
  logic [9:0] push_data_q;
  logic       is_e0;
  logic       is_f0;

  assign is_e0 = (byte_q == 8'hE0);
  assign is_f0 = (byte_q == 8'hF0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
      end else if (byte_ok_q) begin
        case (state_q)
          S_IDLE: begin
            if (is_e0)      state_q <= S_EXT;
            else if (is_f0) state_q <= S_BRK;
            else begin
              push_q      <= 1'b1;
              push_data_q <= {2'b00, byte_q};
            end
          end
          S_EXT: begin
            if (is_f0)      state_q <= S_EXT_BRK;
            else if (!is_e0) begin
              push_q      <= 1'b1;
              push_data_q <= {2'b10, byte_q};
              state_q     <= S_IDLE;
            end
          end
          S_BRK: begin
            if (is_e0)      state_q <= S_EXT_BRK;
            else if (!is_f0) begin
              push_q      <= 1'b1;
              push_data_q <= {2'b01, byte_q};
              state_q     <= S_IDLE;
            end
          end
          default: begin
            if (!(is_e0 || is_f0)) begin
              push_q      <= 1'b1;
              push_data_q <= {2'b11, byte_q};
              state_q     <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic [9:0]       head;

  assign full  = (count_q == FULL_LVL);
  assign pop   = out_valid & out_ready & ~clear;
  // A pop in the same cycle frees the slot the push lands in
  assign wr_en = push_q & ~clear & (~full | pop);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Head fields read as zero when empty so stale RAM contents never leak out
  assign head       = mem[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_code   = out_valid ? head[7:0] : 8'h00;
  assign out_brk    = out_valid & head[8];
  assign out_ext    = out_valid & head[9];
  assign level      = count_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Self-checking bench for ps2_keyboard_fifo: bit-banged PS/2 frames in, scoreboard on the FIFO side.
module tb_ps2_keyboard_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 400;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          ps2_clk;
  logic          ps2_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_code;
  logic          out_ext;
  logic          out_brk;
  logic [CW-1:0] level;
  logic          overflow;
  logic          parity_err;
  logic          frame_err;
  logic          clear;

  ps2_keyboard_fifo #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_ext(out_ext), .out_brk(out_brk), .level(level), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err), .clear(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  logic [9:0] sb [$];

  always @(posedge clk) begin
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit flip);
    logic p;
    p = (~^b) ^ flip;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (4) @(negedge clk); ps2_clk = 1'b0;
      repeat (8) @(negedge clk); ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip);
    send_bits(frame_bits(b, flip), 11);
  endtask

  task automatic send_key(input logic [7:0] b, input bit ext, input bit brk);
    if (ext) send_byte(8'hE0, 1'b0);
    if (brk) send_byte(8'hF0, 1'b0);
    send_byte(b, 1'b0);
    sb.push_back({ext, brk, b});
  endtask

  task automatic pop_one(output logic [9:0] got, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    got = {out_ext, out_brk, out_code};
    if (ok) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_ext, out_brk, out_code, level, overflow, parity_err, frame_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b code=%h level=%0d ovf=%b exp all zero",
               out_valid, out_code, level, overflow);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    logic [10:0] f;
    f = frame_bits(8'h1C, 1'b0);
    send_bits(f, 10);
    @(negedge clk); ps2_data = f[10];
    repeat (4) @(negedge clk); ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", out_valid); end
    total++;
    if ({out_ext, out_brk, out_code, level} !== {2'b00, 8'h1C, CW'(1)}) begin
      bad++;
      $display("FAIL single_head got ext=%b brk=%b code=%h level=%0d exp 0 0 1c 1",
               out_ext, out_brk, out_code, level);
    end
    repeat (7) @(negedge clk); ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    total++;
    if ({out_valid, level} !== {1'b0, CW'(0)}) begin
      bad++; $display("FAIL single_pop got valid=%b level=%0d exp 0 0", out_valid, level);
    end
  endtask

  task automatic test_prefix();
    logic [9:0] got, exp;
    bit ok;
    send_key(8'h1C, 1'b0, 1'b1);
    send_key(8'h75, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    total++;
    if (level !== CW'(2)) begin bad++; $display("FAIL prefix_level got=%0d exp=2", level); end
    send_key(8'h33, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      pop_one(got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp) begin
        bad++; $display("FAIL prefix_event%0d got=%h exp=%h ok=%b", k, got, exp, ok);
      end
    end
  endtask

  task automatic test_parity();
    logic [9:0] got, exp;
    bit ok;
    int p0;
    p0 = perr_cnt;
    send_byte(8'h1C, 1'b1);
    repeat (5) @(negedge clk);
    total++;
    if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL parity_pulses got=%0d exp=1", perr_cnt - p0); end
    total++;
    if (level !== CW'(0)) begin bad++; $display("FAIL parity_nopush got level=%0d exp=0", level); end
    send_key(8'h1C, 1'b0, 1'b0);
    pop_one(got, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL parity_recover got=%h exp=%h ok=%b", got, exp, ok); end
  endtask

  task automatic test_overflow();
    logic [9:0] got, exp;
    bit ok;
    for (int k = 1; k <= 9; k++) begin
      send_byte(8'(k), 1'b0);
      if (k <= DEPTH) sb.push_back({2'b00, 8'(k)});
      repeat (4) @(negedge clk);
      if (k == 8) begin
        total++;
        if ({level, overflow} !== {CW'(8), 1'b0}) begin
          bad++; $display("FAIL ovf_full got level=%0d ovf=%b exp 8 0", level, overflow);
        end
      end
    end
    total++;
    if ({level, overflow} !== {CW'(8), 1'b1}) begin
      bad++; $display("FAIL ovf_drop got level=%0d ovf=%b exp 8 1", level, overflow);
    end
    for (int k = 0; k < DEPTH; k++) begin
      pop_one(got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h ok=%b", k, got, exp, ok); end
    end
    total++;
    if ({level, overflow} !== {CW'(0), 1'b1}) begin
      bad++; $display("FAIL ovf_sticky got level=%0d ovf=%b exp 0 1", level, overflow);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, level} !== {1'b0, CW'(0)}) begin
      bad++; $display("FAIL empty_ready got valid=%b level=%0d exp 0 0", out_valid, level);
    end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_timeout();
    logic [9:0] got, exp;
    bit ok;
    int f0;
    f0 = ferr_cnt;
    send_bits(frame_bits(8'h2A, 1'b0), 5);
    repeat (TMO + 50) @(negedge clk);
    total++;
    if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", ferr_cnt - f0); end
    send_key(8'h2A, 1'b0, 1'b0);
    pop_one(got, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL timeout_recover got=%h exp=%h ok=%b", got, exp, ok); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got, exp;
    bit ok;
    send_key(8'h11, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_bits(frame_bits(8'h75, 1'b0), 5);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill got valid=%b exp=1", out_valid); end
    @(negedge clk); reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_ext, out_brk, out_code, level, overflow, parity_err, frame_err} !== '0) begin
      bad++;
      $display("FAIL mid_reset got valid=%b code=%h level=%0d exp all zero", out_valid, out_code, level);
    end
    sb.delete();
    repeat (3) @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    send_key(8'h75, 1'b0, 1'b0);
    pop_one(got, ok);
    exp = sb.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL mid_after got=%h exp=%h ok=%b", got, exp, ok); end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
